alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station and issue scheduler for the combinational integer ALU. It buffers up to DEPTH dispatched arithmetic, branch-compare and JALR operations and snoops two CDB result buses to wake up operands. Each cycle it selects one ready entry and drives it to the ALU through registered outputs. It sits between the dispatcher/ROB and the ALU, and is cleared on branch misprediction.

## Interface
- DEPTH, 8, number of RS entries (power of 2)
- ROB_W, 4, ROB index width
- OP_W, 6, decoded instruction-type width (ALU `insty` encoding)
- XLEN, 32, operand width
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global ready; 0 freezes the block
- jp_wrong  in  1  misprediction flush
- dsp_flag  in  1  dispatch valid
- dsp_insty  in  OP_W  instruction type
- dsp_q1_busy, dsp_q2_busy  in  1 each  operand still pending
- dsp_q1, dsp_q2  in  ROB_W each  producer ROB tag, valid when busy
- dsp_v1, dsp_v2  in  XLEN each  operand value, valid when not busy; immediates arrive in v2 with q2_busy=0
- dsp_rob_idx  in  ROB_W  destination ROB entry
- rs_full  out  1  no free entry (combinational from registered occupancy)
- cdb0_flag/cdb0_idx/cdb0_val  in  1/ROB_W/XLEN  ALU result bus (ALU output looped back)
- cdb1_flag/cdb1_idx/cdb1_val  in  1/ROB_W/XLEN  load/store result bus
- ins_flag  out  1  issue valid to ALU (registered)
- insty  out  OP_W  issued instruction type
- val1, val2  out  XLEN each  issued operands
- ROB_idx  out  ROB_W  issued destination tag

## Operation
- Entry state: busy, insty, q1_busy, q1, v1, q2_busy, q2, v2, rob_idx. An entry is ready when busy and both q*_busy are 0.
- Dispatch: if dsp_flag and !rs_full, write the lowest-index free entry. If a dispatched operand tag matches a CDB tag that is valid in the same cycle, capture that value and clear the operand's busy bit. cdb0 has priority over cdb1 on an identical tag, though this cannot legally occur. A dispatch while rs_full is a protocol error and is dropped.
- Wakeup: for every busy entry and operand with q*_busy=1, a matching cdbN_idx with cdbN_flag writes v* and clears q*_busy.
- Select/issue: choose the lowest-index ready entry as registered state before this edge. At the edge, copy it to the output registers, set ins_flag=1 and free the entry. If no entry is ready, ins_flag=0 and the other outputs hold.
- Occupancy counter: +1 on accepted dispatch, −1 on issue, unchanged if both occur. rs_full = (count == DEPTH).
- jp_wrong=1 at an edge with rdy=1: clear all busy bits, count=0, ins_flag=0. Same-cycle dispatch, wakeup and issue are discarded.
- rdy=0: no register changes, including ins_flag. Outputs stay stable, so any downstream rebroadcast is idempotent.

## Timing
- Reset (rst=0, asynchronous): all entries free, count=0, rs_full=0, ins_flag=0, insty=0, val1=0, val2=0, ROB_idx=0.
- Dispatch at edge t: the entry becomes valid after t. An already-ready entry issues at edge t+1, so ins_flag is high during cycle t+1..t+2. Minimum dispatch-to-ALU latency is 1 cycle.
- Wakeup: a CDB broadcast during cycle c updates the entry at the end of c. The entry can issue at the next edge. Back-to-back dependent ALU ops therefore issue every 2 cycles.
- Throughput: one issue and one dispatch per cycle.
- An issued entry frees at the same edge it issues. rs_full drops the cycle after that edge, and no same-cycle credit is given.
- Boundary: with count=DEPTH and a simultaneous issue, the dispatch is still refused that cycle.
- Flush has priority over everything except reset.

## Test plan
- Reset mid-run: pulse rst low with 5 entries busy. Required: ins_flag=0, rs_full=0 immediately without waiting for a clock edge, and no issue in the following cycles until a new dispatch.
- Ready dispatch: ADDI, v1=5, v2=7, rob 3 at edge 0. Required: ins_flag=1, insty=ADDI, val1=5, val2=7, ROB_idx=3 after edge 1, and ins_flag=0 after edge 2.
- Wakeup chain: ADD with q1 pending on rob 2, then cdb1_flag=1, idx=2, val=0x10 for one cycle. Required: issue at the next edge with val1=0x10.
- Same-cycle capture: dispatch SUB with q2 pending on tag 4 while cdb0 broadcasts idx=4, val=9. Required: issue the next edge with val2=9, with no hang.
- Full/priority: fill 8 not-ready entries, then set rs_full=1 and attempt a 9th dispatch. Required: it is dropped. Then wake entries 6 and 2 in the same cycle. Required: entry 2 issues first and entry 6 issues next cycle.
- Flush: 4 busy entries plus a same-cycle dispatch with jp_wrong=1. Required: count=0, ins_flag=0 next cycle, and no later issue of any flushed rob_idx.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station and issue scheduler feeding the integer ALU.
// Holds up to DEPTH dispatched ops, snoops two CDBs to wake pending operands,
// and issues the lowest-index ready entry each cycle via registered outputs.
module alu_rs #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 4,
    parameter int OP_W  = 6,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jp_wrong,

    input  logic             dsp_flag,
    input  logic [OP_W-1:0]  dsp_insty,
    input  logic             dsp_q1_busy,
    input  logic             dsp_q2_busy,
    input  logic [ROB_W-1:0] dsp_q1,
    input  logic [ROB_W-1:0] dsp_q2,
    input  logic [XLEN-1:0]  dsp_v1,
    input  logic [XLEN-1:0]  dsp_v2,
    input  logic [ROB_W-1:0] dsp_rob_idx,
    output logic             rs_full,

    input  logic             cdb0_flag,
    input  logic [ROB_W-1:0] cdb0_idx,
    input  logic [XLEN-1:0]  cdb0_val,
    input  logic             cdb1_flag,
    input  logic [ROB_W-1:0] cdb1_idx,
    input  logic [XLEN-1:0]  cdb1_val,

    output logic             ins_flag,
    output logic [OP_W-1:0]  insty,
    output logic [XLEN-1:0]  val1,
    output logic [XLEN-1:0]  val2,
    output logic [ROB_W-1:0] ROB_idx
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Registered entry state
    logic             r_busy    [DEPTH];
    logic [OP_W-1:0]  r_insty   [DEPTH];
    logic             r_q1_busy [DEPTH];
    logic [ROB_W-1:0] r_q1      [DEPTH];
    logic [XLEN-1:0]  r_v1      [DEPTH];
    logic             r_q2_busy [DEPTH];
    logic [ROB_W-1:0] r_q2      [DEPTH];
    logic [XLEN-1:0]  r_v2      [DEPTH];
    logic [ROB_W-1:0] r_rob     [DEPTH];

    logic [CNT_W-1:0] r_count;

    // Registered issue port
    logic             r_ins_flag;
    logic [OP_W-1:0]  r_insty_o;
    logic [XLEN-1:0]  r_val1;
    logic [XLEN-1:0]  r_val2;
    logic [ROB_W-1:0] r_rob_o;

    // Next-state entry values
    logic             w_nxt_busy    [DEPTH];
    logic [OP_W-1:0]  w_nxt_insty   [DEPTH];
    logic             w_nxt_q1_busy [DEPTH];
    logic [ROB_W-1:0] w_nxt_q1      [DEPTH];
    logic [XLEN-1:0]  w_nxt_v1      [DEPTH];
    logic             w_nxt_q2_busy [DEPTH];
    logic [ROB_W-1:0] w_nxt_q2      [DEPTH];
    logic [XLEN-1:0]  w_nxt_v2      [DEPTH];
    logic [ROB_W-1:0] w_nxt_rob     [DEPTH];

    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_rdy_found;
    logic [IDX_W-1:0] w_rdy_idx;
    logic             w_full;
    logic             w_dsp_acc;
    logic             w_issue;

    logic             w_dsp_q1_busy;
    logic [XLEN-1:0]  w_dsp_v1;
    logic             w_dsp_q2_busy;
    logic [XLEN-1:0]  w_dsp_v2;

    // Resolve one pending operand against both CDBs; cdb0 wins on a tag tie.
    // Result is {still_busy, value}.
    function automatic logic [XLEN:0] snoop(input logic             busy,
                                            input logic [ROB_W-1:0] tag,
                                            input logic [XLEN-1:0]  val);
        logic [XLEN:0] res;
        res = {busy, val};
        if (busy) begin
            if (cdb0_flag && (cdb0_idx == tag)) begin
                res = {1'b0, cdb0_val};
            end else if (cdb1_flag && (cdb1_idx == tag)) begin
                res = {1'b0, cdb1_val};
            end
        end
        return res;
    endfunction

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_dsp_acc = dsp_flag && !w_full && w_free_found;
    assign w_issue   = w_rdy_found;

    assign rs_full  = w_full;
    assign ins_flag = r_ins_flag;
    assign insty    = r_insty_o;
    assign val1     = r_val1;
    assign val2     = r_val2;
    assign ROB_idx  = r_rob_o;

    // Lowest-index free entry (scan downward so the lowest match wins)
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index ready entry, judged on registered state only
    always_comb begin
        w_rdy_found = 1'b0;
        w_rdy_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_busy[i] && !r_q1_busy[i] && !r_q2_busy[i]) begin
                w_rdy_found = 1'b1;
                w_rdy_idx   = IDX_W'(i);
            end
        end
    end

    // Dispatched operands may be satisfied by a same-cycle CDB broadcast
    always_comb begin
        w_dsp_q1_busy = dsp_q1_busy;
        w_dsp_v1      = dsp_v1;
        w_dsp_q2_busy = dsp_q2_busy;
        w_dsp_v2      = dsp_v2;
        {w_dsp_q1_busy, w_dsp_v1} = snoop(dsp_q1_busy, dsp_q1, dsp_v1);
        {w_dsp_q2_busy, w_dsp_v2} = snoop(dsp_q2_busy, dsp_q2, dsp_v2);
    end

    // Per-entry next state: wakeup, then issue frees, then dispatch writes
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt_busy[i]    = r_busy[i];
            w_nxt_insty[i]   = r_insty[i];
            w_nxt_q1_busy[i] = r_q1_busy[i];
            w_nxt_q1[i]      = r_q1[i];
            w_nxt_v1[i]      = r_v1[i];
            w_nxt_q2_busy[i] = r_q2_busy[i];
            w_nxt_q2[i]      = r_q2[i];
            w_nxt_v2[i]      = r_v2[i];
            w_nxt_rob[i]     = r_rob[i];

            if (r_busy[i]) begin
                {w_nxt_q1_busy[i], w_nxt_v1[i]} = snoop(r_q1_busy[i], r_q1[i], r_v1[i]);
                {w_nxt_q2_busy[i], w_nxt_v2[i]} = snoop(r_q2_busy[i], r_q2[i], r_v2[i]);
            end

            if (w_issue && (w_rdy_idx == IDX_W'(i))) begin
                w_nxt_busy[i] = 1'b0;
            end

            if (w_dsp_acc && (w_free_idx == IDX_W'(i))) begin
                w_nxt_busy[i]    = 1'b1;
                w_nxt_insty[i]   = dsp_insty;
                w_nxt_q1_busy[i] = w_dsp_q1_busy;
                w_nxt_q1[i]      = dsp_q1;
                w_nxt_v1[i]      = w_dsp_v1;
                w_nxt_q2_busy[i] = w_dsp_q2_busy;
                w_nxt_q2[i]      = dsp_q2;
                w_nxt_v2[i]      = w_dsp_v2;
                w_nxt_rob[i]     = dsp_rob_idx;
            end
        end
    end

    // Entry storage; a flush only needs to drop the busy bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]    <= 1'b0;
                r_insty[i]   <= '0;
                r_q1_busy[i] <= 1'b0;
                r_q1[i]      <= '0;
                r_v1[i]      <= '0;
                r_q2_busy[i] <= 1'b0;
                r_q2[i]      <= '0;
                r_v2[i]      <= '0;
                r_rob[i]     <= '0;
            end
        end else if (rdy) begin
            if (jp_wrong) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_busy[i] <= 1'b0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_busy[i]    <= w_nxt_busy[i];
                    r_insty[i]   <= w_nxt_insty[i];
                    r_q1_busy[i] <= w_nxt_q1_busy[i];
                    r_q1[i]      <= w_nxt_q1[i];
                    r_v1[i]      <= w_nxt_v1[i];
                    r_q2_busy[i] <= w_nxt_q2_busy[i];
                    r_q2[i]      <= w_nxt_q2[i];
                    r_v2[i]      <= w_nxt_v2[i];
                    r_rob[i]     <= w_nxt_rob[i];
                end
            end
        end
    end

    // Occupancy counter; a dispatch and an issue in the same cycle cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (rdy) begin
            if (jp_wrong) begin
                r_count <= '0;
            end else begin
                case ({w_dsp_acc, w_issue})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Issue register toward the ALU; payload holds when nothing issues
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ins_flag <= 1'b0;
            r_insty_o  <= '0;
            r_val1     <= '0;
            r_val2     <= '0;
            r_rob_o    <= '0;
        end else if (rdy) begin
            if (jp_wrong) begin
                r_ins_flag <= 1'b0;
            end else begin
                r_ins_flag <= w_issue;
                if (w_issue) begin
                    r_insty_o <= r_insty[w_rdy_idx];
                    r_val1    <= r_v1[w_rdy_idx];
                    r_val2    <= r_v2[w_rdy_idx];
                    r_rob_o   <= r_rob[w_rdy_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed bench for alu_rs with a queue-based issue scoreboard.
module tb_alu_rs;

    localparam int DEPTH = 8;
    localparam int ROB_W = 4;
    localparam int OP_W  = 6;
    localparam int XLEN  = 32;

    localparam logic [OP_W-1:0] OP_ADD  = 6'h01;
    localparam logic [OP_W-1:0] OP_SUB  = 6'h02;
    localparam logic [OP_W-1:0] OP_ADDI = 6'h0A;

    logic             clk;
    logic             rst;
    logic             rdy;
    logic             jp_wrong;
    logic             dsp_flag;
    logic [OP_W-1:0]  dsp_insty;
    logic             dsp_q1_busy;
    logic             dsp_q2_busy;
    logic [ROB_W-1:0] dsp_q1;
    logic [ROB_W-1:0] dsp_q2;
    logic [XLEN-1:0]  dsp_v1;
    logic [XLEN-1:0]  dsp_v2;
    logic [ROB_W-1:0] dsp_rob_idx;
    logic             rs_full;
    logic             cdb0_flag;
    logic [ROB_W-1:0] cdb0_idx;
    logic [XLEN-1:0]  cdb0_val;
    logic             cdb1_flag;
    logic [ROB_W-1:0] cdb1_idx;
    logic [XLEN-1:0]  cdb1_val;
    logic             ins_flag;
    logic [OP_W-1:0]  insty;
    logic [XLEN-1:0]  val1;
    logic [XLEN-1:0]  val2;
    logic [ROB_W-1:0] ROB_idx;

    typedef struct packed {
        logic [OP_W-1:0]  ty;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [ROB_W-1:0] rob;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    logic prevRdy;

    alu_rs #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
        .dsp_flag(dsp_flag), .dsp_insty(dsp_insty),
        .dsp_q1_busy(dsp_q1_busy), .dsp_q2_busy(dsp_q2_busy),
        .dsp_q1(dsp_q1), .dsp_q2(dsp_q2), .dsp_v1(dsp_v1), .dsp_v2(dsp_v2),
        .dsp_rob_idx(dsp_rob_idx), .rs_full(rs_full),
        .cdb0_flag(cdb0_flag), .cdb0_idx(cdb0_idx), .cdb0_val(cdb0_val),
        .cdb1_flag(cdb1_flag), .cdb1_idx(cdb1_idx), .cdb1_val(cdb1_val),
        .ins_flag(ins_flag), .insty(insty), .val1(val1), .val2(val2),
        .ROB_idx(ROB_idx)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic [OP_W-1:0] ty,
                                 input logic q1b, input logic [ROB_W-1:0] q1, input logic [XLEN-1:0] v1,
                                 input logic q2b, input logic [ROB_W-1:0] q2, input logic [XLEN-1:0] v2,
                                 input logic [ROB_W-1:0] rob);
        dsp_flag    = f;
        dsp_insty   = ty;
        dsp_q1_busy = q1b;
        dsp_q1      = q1;
        dsp_v1      = v1;
        dsp_q2_busy = q2b;
        dsp_q2      = q2;
        dsp_v2      = v2;
        dsp_rob_idx = rob;
    endtask

    task automatic driveCdb(input logic f0, input logic [ROB_W-1:0] i0, input logic [XLEN-1:0] v0,
                            input logic f1, input logic [ROB_W-1:0] i1, input logic [XLEN-1:0] v1);
        cdb0_flag = f0;
        cdb0_idx  = i0;
        cdb0_val  = v0;
        cdb1_flag = f1;
        cdb1_idx  = i1;
        cdb1_val  = v1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        driveCdb(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic pushExp(input logic [OP_W-1:0] ty, input logic [XLEN-1:0] v1,
                           input logic [XLEN-1:0] v2, input logic [ROB_W-1:0] rob);
        exp_t e;
        e.ty  = ty;
        e.v1  = v1;
        e.v2  = v2;
        e.rob = rob;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remember whether the last edge was allowed to update the DUT
    always @(posedge clk) prevRdy <= rdy;

    // Monitor: every fresh issue must match the oldest expected issue
    always @(negedge clk) begin
        if (rst && (prevRdy === 1'b1) && ins_flag) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_issue: got issue of rob %0d, expected no issue", ROB_idx);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("issue_insty", 32'(insty), 32'(e.ty));
                checkOutput("issue_val1", val1, e.v1);
                checkOutput("issue_val2", val2, e.v2);
                checkOutput("issue_rob", 32'(ROB_idx), 32'(e.rob));
            end
        end
    end

    // Directed sequence
    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        jp_wrong = 1'b0;
        idle();
        #1 rst = 1'b0;
        #2;
        checkOutput("reset_ins_flag", 32'(ins_flag), 0);
        checkOutput("reset_rs_full", 32'(rs_full), 0);
        checkOutput("reset_insty", 32'(insty), 0);
        checkOutput("reset_val1", val1, 0);
        checkOutput("reset_val2", val2, 0);
        checkOutput("reset_rob", 32'(ROB_idx), 0);
        @(negedge clk);
        rst = 1'b1;

        // Ready dispatch issues one edge later, for exactly one cycle
        applyStimulus(1'b1, OP_ADDI, 1'b0, '0, 32'd5, 1'b0, '0, 32'd7, 4'd3);
        pushExp(OP_ADDI, 32'd5, 32'd7, 4'd3);
        tick();
        idle();
        tick();
        checkOutput("ready_issue_flag", 32'(ins_flag), 1);
        tick();
        checkOutput("ready_flag_drop", 32'(ins_flag), 0);

        // rdy=0 freezes the block even with a ready entry waiting
        applyStimulus(1'b1, OP_ADD, 1'b0, '0, 32'h11, 1'b0, '0, 32'h22, 4'd4);
        pushExp(OP_ADD, 32'h11, 32'h22, 4'd4);
        tick();
        idle();
        rdy = 1'b0;
        tick();
        tick();
        checkOutput("freeze_no_issue", 32'(ins_flag), 0);
        checkOutput("freeze_hold_rob", 32'(ROB_idx), 3);
        rdy = 1'b1;
        tick();
        tick();

        // Wakeup via cdb1, then issue at the following edge
        applyStimulus(1'b1, OP_ADD, 1'b1, 4'd2, '0, 1'b0, '0, 32'h20, 4'd5);
        tick();
        idle();
        tick();
        tick();
        checkOutput("wait_no_issue", 32'(ins_flag), 0);
        driveCdb(1'b0, '0, '0, 1'b1, 4'd2, 32'h10);
        pushExp(OP_ADD, 32'h10, 32'h20, 4'd5);
        tick();
        idle();
        tick();
        checkOutput("wake_issue_flag", 32'(ins_flag), 1);
        tick();

        // Operand captured from cdb0 in the dispatch cycle
        applyStimulus(1'b1, OP_SUB, 1'b0, '0, 32'd3, 1'b1, 4'd4, '0, 4'd6);
        driveCdb(1'b1, 4'd4, 32'd9, 1'b0, '0, '0);
        pushExp(OP_SUB, 32'd3, 32'd9, 4'd6);
        tick();
        idle();
        tick();
        tick();

        // Fill all entries with ops waiting on tags 8..15
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b1, OP_ADD, 1'b1, 4'(k + 8), '0, 1'b0, '0, 32'(k), 4'(k));
            tick();
            if (k == DEPTH - 2) checkOutput("fill_7_not_full", 32'(rs_full), 0);
        end
        idle();
        checkOutput("fill_8_full", 32'(rs_full), 1);
        applyStimulus(1'b1, OP_ADDI, 1'b0, '0, 32'hDEAD, 1'b0, '0, 32'd1, 4'd15);
        tick();
        idle();
        checkOutput("drop_keeps_full", 32'(rs_full), 1);
        tick();
        driveCdb(1'b1, 4'd14, 32'h66, 1'b1, 4'd10, 32'h22);
        pushExp(OP_ADD, 32'h22, 32'd2, 4'd2);
        pushExp(OP_ADD, 32'h66, 32'd6, 4'd6);
        tick();
        idle();
        applyStimulus(1'b1, OP_ADDI, 1'b0, '0, 32'hBEEF, 1'b0, '0, 32'd1, 4'd13);
        tick();
        idle();
        checkOutput("boundary_full_drops", 32'(rs_full), 0);
        tick();
        checkOutput("second_issue_flag", 32'(ins_flag), 1);
        tick();

        // Flush while entry 0 is ready and a new op is dispatched
        driveCdb(1'b1, 4'd8, 32'h88, 1'b0, '0, '0);
        tick();
        jp_wrong = 1'b1;
        driveCdb(1'b1, 4'd9, 32'h99, 1'b0, '0, '0);
        applyStimulus(1'b1, OP_ADDI, 1'b0, '0, 32'h77, 1'b0, '0, 32'd1, 4'd12);
        tick();
        jp_wrong = 1'b0;
        idle();
        checkOutput("flush_ins_flag", 32'(ins_flag), 0);
        checkOutput("flush_not_full", 32'(rs_full), 0);
        for (int t = 8; t < 16; t++) begin
            driveCdb(1'b1, 4'(t), 32'(t), 1'b0, '0, '0);
            tick();
        end
        idle();
        tick();
        tick();

        // Refill shows the counter restarted from zero
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b1, OP_ADD, 1'b1, 4'(k + 8), '0, 1'b0, '0, 32'(k), 4'(k));
            tick();
            if (k == DEPTH - 2) checkOutput("refill_7_not_full", 32'(rs_full), 0);
        end
        idle();
        checkOutput("refill_8_full", 32'(rs_full), 1);

        // Asynchronous reset in the middle of an issue cycle
        driveCdb(1'b1, 4'd8, 32'hAB, 1'b0, '0, '0);
        tick();
        idle();
        tick();
        checkOutput("pre_reset_flag", 32'(ins_flag), 1);
        checkOutput("pre_reset_val1", val1, 32'hAB);
        #1 rst = 1'b0;
        #1;
        checkOutput("midreset_ins_flag", 32'(ins_flag), 0);
        checkOutput("midreset_rs_full", 32'(rs_full), 0);
        checkOutput("midreset_val1", val1, 0);
        checkOutput("midreset_rob", 32'(ROB_idx), 0);
        #1 rst = 1'b1;
        for (int t = 8; t < 16; t++) begin
            driveCdb(1'b1, 4'(t), 32'(t), 1'b0, '0, '0);
            tick();
        end
        idle();
        tick();
        checkOutput("post_reset_not_full", 32'(rs_full), 0);

        // A fresh dispatch still works after reset
        applyStimulus(1'b1, OP_ADD, 1'b0, '0, 32'd1, 1'b0, '0, 32'd2, 4'd7);
        pushExp(OP_ADD, 32'd1, 32'd2, 4'd7);
        tick();
        idle();
        tick();
        tick();
        tick();

        checkOutput("scoreboard_drained", 32'(expQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
